wide_lt_sched: RTL and testbench

Shared-comparator scheduler for wide unsigned less-than checks in the crypto datapath. Up to NREQ requesters each submit a pair of WORDS×32-bit unsigned operands. The block arbitrates round-robin and walks the single 32-bit lt/eq comparator word by word, most-significant word first, stopping at the first unequal word. It returns one lt/eq verdict per request, tagged with the requester id.

---
 rtl/wide_lt_sched.sv | 161 ++++++++++++++++
 tb/tb_wide_lt_sched.sv | 398 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/wide_lt_sched.sv
// wide_lt_sched
//   Shared-comparator scheduler for wide unsigned less-than checks.
//   NREQ requesters each offer a pair of WORDS x 32-bit operands. A
//   round-robin arbiter picks one pair. A single 32-bit comparator then walks
//   the pair from the most-significant word down and stops at the first word
//   that differs. The block returns one lt/eq verdict, tagged with the id of
//   the requester that owns it.
//
// Ports
//   clk        rising-edge clock
//   rst        asynchronous, active-high reset
//   req_valid  [NREQ]       requester i has an operand pair pending
//   req_a      [NREQ*OPW]   operand A of requester i at [i*OPW +: OPW]
//   req_b      [NREQ*OPW]   operand B, same layout
//   req_ready  [NREQ]       one-hot accept strobe (IDLE only)
//   rsp_valid               verdict available
//   rsp_ready               consumer accepts the verdict
//   rsp_id     [IDW]        requester that owns the verdict
//   rsp_lt                  A < B (unsigned)
//   rsp_eq                  A == B
//   busy                    an operation is in flight
module wide_lt_sched #(
    parameter int  NREQ  = 4,
    parameter int  WORDS = 8,
    localparam int IDW   = $clog2(NREQ),
    localparam int OPW   = 32 * WORDS
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NREQ-1:0]      req_valid,
    input  logic [NREQ*OPW-1:0]  req_a,
    input  logic [NREQ*OPW-1:0]  req_b,
    output logic [NREQ-1:0]      req_ready,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [IDW-1:0]       rsp_id,
    output logic                 rsp_lt,
    output logic                 rsp_eq,
    output logic                 busy
);

    localparam int IW = (WORDS > 1) ? $clog2(WORDS) : 1;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_CMP  = 2'd1;
    localparam logic [1:0] S_RESP = 2'd2;

    logic [1:0]      state;
    logic [IDW-1:0]  rr_ptr;
    logic [IW-1:0]   idx;
    logic [IDW-1:0]  id_q;
    logic            lt_q;
    logic            eq_q;
    logic [OPW-1:0]  a_q;
    logic [OPW-1:0]  b_q;

    logic            found;
    logic [IDW-1:0]  grant_id;
    logic [IDW-1:0]  next_ptr;
    logic [NREQ-1:0] grant_oh;
    logic [OPW-1:0]  grant_a;
    logic [OPW-1:0]  grant_b;
    logic [31:0]     a_word;
    logic [31:0]     b_word;

    // Round-robin search: first valid requester at or after rr_ptr, wrapping.
    // The operand slices of the winner are selected here too, so the capture
    // below needs no second variable-index mux.
    always_comb begin
        int unsigned j;
        j        = 0;
        found    = 1'b0;
        grant_id = '0;
        grant_a  = '0;
        grant_b  = '0;
        for (int unsigned k = 0; k < NREQ; k++) begin
            j = (32'(rr_ptr) + k) % NREQ;
            if (!found && req_valid[j]) begin
                found    = 1'b1;
                grant_id = IDW'(j);
                grant_a  = req_a[j*OPW +: OPW];
                grant_b  = req_b[j*OPW +: OPW];
            end
        end
    end

    assign grant_oh = found ? (NREQ'(1) << grant_id) : '0;
    assign next_ptr = (grant_id == IDW'(NREQ - 1)) ? '0 : grant_id + IDW'(1);

    // Grants are offered only while idle and out of reset. rsp_ready has no
    // path to req_ready because a response always costs a cycle back in IDLE.
    assign req_ready = (state == S_IDLE && !rst) ? grant_oh : '0;

    // Word currently under comparison; idx walks from WORDS-1 down to 0.
    assign a_word = a_q[{idx, 5'd0} +: 32];
    assign b_word = b_q[{idx, 5'd0} +: 32];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= S_IDLE;
            rr_ptr <= '0;
            idx    <= '0;
            id_q   <= '0;
            lt_q   <= 1'b0;
            eq_q   <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    // The winner is valid and its ready is high, so a found
                    // winner is a completed handshake.
                    if (found) begin
                        id_q   <= grant_id;
                        rr_ptr <= next_ptr;
                        idx    <= IW'(WORDS - 1);
                        state  <= S_CMP;
                    end
                end
                S_CMP: begin
                    if (a_word < b_word) begin
                        lt_q  <= 1'b1;
                        eq_q  <= 1'b0;
                        state <= S_RESP;
                    end else if (a_word > b_word) begin
                        lt_q  <= 1'b0;
                        eq_q  <= 1'b0;
                        state <= S_RESP;
                    end else if (idx == '0) begin
                        lt_q  <= 1'b0;
                        eq_q  <= 1'b1;
                        state <= S_RESP;
                    end else begin
                        idx <= idx - IW'(1);
                    end
                end
                S_RESP: begin
                    if (rsp_ready) begin
                        state <= S_IDLE;
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    // Operand copies need no reset: they are read only after a capture.
    always_ff @(posedge clk) begin
        if (state == S_IDLE && found) begin
            a_q <= grant_a;
            b_q <= grant_b;
        end
    end

    assign rsp_valid = (state == S_RESP);
    assign rsp_id    = id_q;
    assign rsp_lt    = lt_q;
    assign rsp_eq    = eq_q;
    assign busy      = (state != S_IDLE);

endmodule

// File: tb/tb_wide_lt_sched.sv
// tb_wide_lt_sched
//   Bench for wide_lt_sched. A transaction-level reference model checks
//   every output on every falling edge. The model predicts the grant by
//   searching from a pointer, the verdict by comparing the full-width
//   operands, and the latency by counting the words examined.
//   Directed cases pin the model with literal expectations, and a randomized
//   phase follows them.
module tb_wide_lt_sched;

    localparam int NREQ  = 4;
    localparam int WORDS = 8;
    localparam int IDW   = 2;
    localparam int OPW   = 32 * WORDS;

    logic                clk = 1'b0;
    logic                rst;
    logic [NREQ-1:0]     req_valid;
    logic [NREQ*OPW-1:0] req_a;
    logic [NREQ*OPW-1:0] req_b;
    logic [NREQ-1:0]     req_ready;
    logic                rsp_valid;
    logic                rsp_ready;
    logic [IDW-1:0]      rsp_id;
    logic                rsp_lt;
    logic                rsp_eq;
    logic                busy;

    logic [OPW-1:0] op_a [NREQ];
    logic [OPW-1:0] op_b [NREQ];

    for (genvar g = 0; g < NREQ; g++) begin : g_pack
        assign req_a[g*OPW +: OPW] = op_a[g];
        assign req_b[g*OPW +: OPW] = op_b[g];
    end

    wide_lt_sched #(.NREQ(NREQ), .WORDS(WORDS)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_a(req_a),
        .req_b(req_b), .req_ready(req_ready), .rsp_valid(rsp_valid),
        .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_lt(rsp_lt),
        .rsp_eq(rsp_eq), .busy(busy)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // model: 0 = idle, 1 = comparing (m_cnt words left), 2 = responding
    int             m_state = 0;
    int             m_ptr   = 0;
    int             m_cnt   = 0;
    int             m_id    = 0;
    logic [OPW-1:0] m_a;
    logic [OPW-1:0] m_b;

    int   cyc           = 0;
    int   acc_cyc       = 0;
    int   rsp_first_cyc = 0;
    int   rsp_rise_cnt  = 0;
    int   rsp_done_cnt  = 0;
    bit   rsp_seen      = 0;
    int   last_id       = 0;
    logic last_lt       = 0;
    logic last_eq       = 0;
    int   grant_log[$];
    bit   accepted[NREQ];
    bit   auto_drop     = 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [OPW-1:0] fill(input logic [31:0] v);
        logic [OPW-1:0] r;
        for (int w = 0; w < WORDS; w++) r[w*32 +: 32] = v;
        return r;
    endfunction

    // Compare process: checks the DUT against the model, then advances the model.
    initial begin
        int g;
        int j;
        int k;
        logic [NREQ-1:0] er;
        forever begin
            @(negedge clk);
            cyc++;
            if (rst) begin
                chk("rst_req_ready", req_ready, 0);
                chk("rst_rsp_valid", rsp_valid, 0);
                chk("rst_rsp_id", rsp_id, 0);
                chk("rst_rsp_lt", rsp_lt, 0);
                chk("rst_rsp_eq", rsp_eq, 0);
                chk("rst_busy", busy, 0);
                m_state  = 0;
                m_ptr    = 0;
                rsp_seen = 0;
            end else begin
                g  = -1;
                er = '0;
                if (m_state == 0) begin
                    for (int n = 0; n < NREQ; n++) begin
                        j = (m_ptr + n) % NREQ;
                        if (g < 0 && req_valid[j]) g = j;
                    end
                end
                if (g >= 0) er[g] = 1'b1;
                chk("req_ready", req_ready, er);
                chk("busy", busy, m_state != 0);
                chk("rsp_valid", rsp_valid, m_state == 2);
                chk("lt_eq_exclusive", rsp_lt & rsp_eq, 0);
                if (m_state == 2) begin
                    chk("rsp_id", rsp_id, m_id);
                    chk("rsp_lt", rsp_lt, m_a < m_b);
                    chk("rsp_eq", rsp_eq, m_a == m_b);
                    if (!rsp_seen) begin
                        rsp_seen      = 1;
                        rsp_first_cyc = cyc;
                        rsp_rise_cnt++;
                        last_id = rsp_id;
                        last_lt = rsp_lt;
                        last_eq = rsp_eq;
                    end
                    if (rsp_ready) begin
                        m_state = 0;
                        rsp_done_cnt++;
                    end
                end else if (m_state == 1) begin
                    m_cnt--;
                    if (m_cnt == 0) m_state = 2;
                end else if (g >= 0) begin
                    m_a   = op_a[g];
                    m_b   = op_b[g];
                    m_id  = g;
                    m_ptr = (g + 1) % NREQ;
                    k = 0;
                    for (int w = WORDS - 1; w >= 0; w--) begin
                        k++;
                        if (m_a[w*32 +: 32] != m_b[w*32 +: 32]) break;
                    end
                    m_cnt       = k;
                    m_state     = 1;
                    acc_cyc     = cyc;
                    rsp_seen    = 0;
                    accepted[g] = 1;
                    grant_log.push_back(g);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
        for (int i = 0; i < NREQ; i++) begin
            if (accepted[i]) begin
                accepted[i] = 0;
                if (auto_drop) req_valid[i] = 1'b0;
            end
        end
    endtask

    task automatic wait_rsp(input int n, input int budget, input string tag);
        int c;
        c = 0;
        while (rsp_done_cnt < n && c < budget) begin
            tick();
            c++;
        end
        chk({tag, "_done"}, rsp_done_cnt >= n, 1);
    endtask

    task automatic do_op(input int id, input logic [OPW-1:0] a, input logic [OPW-1:0] b,
                         input int lat, input logic lt, input logic eq, input string tag);
        int base;
        op_a[id]      = a;
        op_b[id]      = b;
        rsp_ready     = 1'b1;
        req_valid[id] = 1'b1;
        base          = rsp_done_cnt;
        wait_rsp(base + 1, 40, tag);
        chk({tag, "_latency"}, rsp_first_cyc - acc_cyc, lat);
        chk({tag, "_id"}, last_id, id);
        chk({tag, "_lt"}, last_lt, lt);
        chk({tag, "_eq"}, last_eq, eq);
    endtask

    task automatic rand_pair(output logic [OPW-1:0] a, output logic [OPW-1:0] b);
        int mode;
        mode = $urandom_range(0, 5);
        for (int w = 0; w < WORDS; w++) begin
            a[w*32 +: 32] = $urandom;
            b[w*32 +: 32] = a[w*32 +: 32];
            if (mode != 0) begin
                case ($urandom_range(0, 7))
                    0:       b[w*32 +: 32] = $urandom;
                    1:       b[w*32 +: 32] = a[w*32 +: 32] ^ 32'h8000_0000;
                    2:       b[w*32 +: 32] = a[w*32 +: 32] + 32'd1;
                    default: b[w*32 +: 32] = a[w*32 +: 32];
                endcase
            end
        end
    endtask

    initial begin
        logic [OPW-1:0] a;
        logic [OPW-1:0] b;
        int base;
        int start;
        int c;
        int r0;
        int sg;

        rst       = 1'b1;
        req_valid = '0;
        rsp_ready = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            op_a[i] = '0;
            op_b[i] = '0;
        end

        // 1: reset
        repeat (3) tick();
        rst = 1'b0;
        tick();
        chk("t1_busy", busy, 0);
        chk("t1_req_ready", req_ready, 0);

        // 2: decision in the top word, response held back for 5 cycles
        a = fill(32'h1234_5678);
        b = a;
        a[7*32 +: 32] = 32'h0000_0001;
        b[7*32 +: 32] = 32'h0000_0002;
        op_a[1] = a;
        op_b[1] = b;
        req_valid[1] = 1'b1;
        r0 = rsp_rise_cnt;
        c  = 0;
        while (rsp_rise_cnt == r0 && c < 30) begin
            tick();
            c++;
        end
        chk("t2_rsp_seen", rsp_rise_cnt != r0, 1);
        chk("t2_latency", rsp_first_cyc - acc_cyc, 2);
        chk("t2_id", last_id, 1);
        chk("t2_lt", last_lt, 1);
        chk("t2_eq", last_eq, 0);
        op_a[0] = fill(32'h0);
        op_b[0] = fill(32'h0);
        req_valid[0] = 1'b1;
        repeat (5) tick();
        chk("t2_hold_valid", rsp_valid, 1);
        chk("t2_hold_id", rsp_id, 1);
        chk("t2_hold_lt", rsp_lt, 1);
        chk("t2_hold_eq", rsp_eq, 0);
        chk("t2_hold_ready", req_ready, 0);
        rsp_ready = 1'b1;
        base = rsp_done_cnt;
        wait_rsp(base + 2, 40, "t2_drain");
        chk("t2_next_id", last_id, 0);
        chk("t2_next_eq", last_eq, 1);

        // 3: full walk, equal operands and a difference in word 0
        do_op(2, fill(32'hDEAD_BEEF), fill(32'hDEAD_BEEF), 9, 1'b0, 1'b1, "t3_equal");
        a = fill(32'hDEAD_BEEF);
        b = a;
        a[0 +: 32] = 32'hFFFF_FFFF;
        b[0 +: 32] = 32'hFFFF_FFFE;
        do_op(3, a, b, 9, 1'b0, 1'b0, "t3_word0");
        b[0 +: 32] = 32'hFFFF_FFFF;
        a[0 +: 32] = 32'hFFFF_FFFE;
        do_op(0, a, b, 9, 1'b1, 1'b0, "t3_word0_lt");

        // 4: unsigned compare in word 3; words 7..3 examined, lower words ignored
        a = fill(32'h0000_0055);
        b = a;
        a[3*32 +: 32] = 32'h8000_0000;
        b[3*32 +: 32] = 32'h7FFF_FFFF;
        for (int w = 0; w < 3; w++) begin
            a[w*32 +: 32] = 32'h0;
            b[w*32 +: 32] = 32'hFFFF_FFFF;
        end
        do_op(1, a, b, 6, 1'b0, 1'b0, "t4_unsigned");

        // 5: round robin from a fresh pointer
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tick();
        for (int i = 0; i < NREQ; i++) begin
            rand_pair(a, b);
            op_a[i] = a;
            op_b[i] = b;
        end
        auto_drop = 0;
        rsp_ready = 1'b1;
        start = grant_log.size();
        req_valid = '1;
        c = 0;
        while (grant_log.size() < start + 5 && c < 100) begin
            tick();
            c++;
        end
        req_valid = '0;
        auto_drop = 1;
        chk("t5_grant_count", grant_log.size() >= start + 5, 1);
        if (grant_log.size() >= start + 5) begin
            chk("t5_order0", grant_log[start], 0);
            chk("t5_order1", grant_log[start + 1], 1);
            chk("t5_order2", grant_log[start + 2], 2);
            chk("t5_order3", grant_log[start + 3], 3);
            chk("t5_order4", grant_log[start + 4], 0);
        end
        base = rsp_done_cnt;
        c = 0;
        while (busy && c < 20) begin
            tick();
            c++;
        end
        chk("t5_idle", busy, 0);
        req_valid[0] = 1'b1;
        req_valid[2] = 1'b1;
        start = grant_log.size();
        base  = rsp_done_cnt;
        wait_rsp(base + 2, 40, "t5_pair");
        if (grant_log.size() >= start + 2) begin
            chk("t5_pair_first", grant_log[start], 2);
            chk("t5_pair_second", grant_log[start + 1], 0);
        end

        // 6: reset during the second comparison cycle
        op_a[3] = fill(32'hA5A5_A5A5);
        op_b[3] = fill(32'hA5A5_A5A5);
        req_valid[3] = 1'b1;
        sg = grant_log.size();
        c  = 0;
        while (grant_log.size() == sg && c < 20) begin
            tick();
            c++;
        end
        chk("t6_granted", grant_log.size() > sg, 1);
        chk("t6_granted_id", grant_log[grant_log.size() - 1], 3);
        tick();
        rst = 1'b1;
        r0  = rsp_rise_cnt;
        req_valid[1] = 1'b1;
        req_valid[3] = 1'b1;
        repeat (2) tick();
        rst = 1'b0;
        sg = grant_log.size();
        c  = 0;
        while (grant_log.size() == sg && c < 20) begin
            tick();
            c++;
        end
        chk("t6_no_rsp", rsp_rise_cnt, r0);
        if (grant_log.size() > sg) chk("t6_first_after_rst", grant_log[sg], 1);
        base = rsp_done_cnt;
        wait_rsp(base + 2, 60, "t6_drain");

        // randomized traffic with occasional resets
        for (int n = 0; n < 3000; n++) begin
            tick();
            rst = ($urandom_range(0, 399) == 0);
            rsp_ready = ($urandom_range(0, 9) < 7);
            for (int i = 0; i < NREQ; i++) begin
                if (!req_valid[i]) begin
                    if ($urandom_range(0, 2) == 0) begin
                        rand_pair(a, b);
                        op_a[i] = a;
                        op_b[i] = b;
                        req_valid[i] = 1'b1;
                    end
                end else if ($urandom_range(0, 24) == 0) begin
                    req_valid[i] = 1'b0;
                end
            end
        end
        rst       = 1'b0;
        req_valid = '0;
        rsp_ready = 1'b1;
        c = 0;
        while (m_state != 0 && c < 30) begin
            tick();
            c++;
        end
        tick();
        chk("final_busy", busy, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
